// File: rtl/pc_next_unit.sv
// rtl/pc_next_unit.sv - MIPS program counter and next-PC selector with fetch handshake.
// Optional macro DELAY_SLOT_EN enables branch-delay-slot semantics.
module pc_next_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        halt,
  input  logic        jump,
  input  logic [27:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] pc_plus4,
  output logic [31:0] link_addr,
  output logic        misalign_exc
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t      state;
  logic        accept;
  logic        redirect;
  logic        jr_misaligned;
  logic [31:0] jump_addr;
  logic [31:0] branch_addr;
  logic [31:0] redirect_target;

  assign pc_plus4 = pc + 32'd4;

`ifdef DELAY_SLOT_EN
  // The instruction after the slot returns past the slot itself.
  assign link_addr = pc + 32'd8;
  logic        pending_valid;
  logic [31:0] pending_target;
`else
  assign link_addr = pc_plus4;
`endif

  assign accept        = pc_valid & imem_ready & ~stall;
  assign redirect      = jr | jump | branch_taken;
  assign jr_misaligned = jr & (jr_target[1:0] != 2'b00);
  assign jump_addr     = {pc_plus4[31:28], jump_target};
  assign branch_addr   = pc_plus4 + {branch_offset[29:0], 2'b00};

  always_comb begin
    redirect_target = pc_plus4;
    if (jr) begin
      redirect_target = jr_misaligned ? EXC_VECTOR : jr_target;
    end else if (jump) begin
      redirect_target = jump_addr;
    end else if (branch_taken) begin
      redirect_target = branch_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pc           <= RESET_VECTOR;
      pc_valid     <= 1'b0;
      misalign_exc <= 1'b0;
`ifdef DELAY_SLOT_EN
      pending_valid  <= 1'b0;
      pending_target <= RESET_VECTOR;
`endif
    end else begin
      misalign_exc <= 1'b0;
      case (state)
        S_IDLE: begin
          state    <= S_FETCH;
          pc_valid <= 1'b1;
        end
        S_FETCH: begin
          if (accept) begin
            if (halt) begin
              // The halting fetch is the last one; pc stays on it.
              state    <= S_HALTED;
              pc_valid <= 1'b0;
`ifdef DELAY_SLOT_EN
              pending_valid <= 1'b0;
`endif
            end else begin
`ifdef DELAY_SLOT_EN
              if (pending_valid) begin
                pc            <= pending_target;
                pending_valid <= 1'b0;
              end else begin
                pc <= pc_plus4;
                if (redirect) begin
                  pending_valid  <= 1'b1;
                  pending_target <= redirect_target;
                  misalign_exc   <= jr_misaligned;
                end
              end
`else
              pc           <= redirect ? redirect_target : pc_plus4;
              misalign_exc <= jr_misaligned;
`endif
            end
          end
        end
        S_HALTED: begin
          pc_valid <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
